// File: rtl/tx_dmac.sv
// Burst-mode AXI read DMA: loops AR/R bursts from a base address and forwards
// every read beat straight onto an AXI-Stream port with no internal buffering.
module tx_dmac #(
    parameter int ADDR_W = 48
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              read_enable,
    output logic              read_busy,
    input  logic [ADDR_W-1:0] read_base_address,
    input  logic [31:0]       read_burst_count,
    input  logic [8:0]        read_burst_len,
    output logic [1:0]        read_rresp,
    output logic              read_burst_tick,
    output logic [31:0]       read_total_burst_count,
    input  logic              tx_fifo_space_ready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [127:0]      m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [127:0]      m_axis_tx_tdata,
    output logic              m_axis_tx_tvalid,
    input  logic              m_axis_tx_tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       burst_cnt;
    logic [31:0]       burst_cnt_inc;
    logic [ADDR_W-1:0] burst_bytes;
    logic              start_ok;
    logic              beat_ok;
    logic              burst_end;

    assign start_ok      = read_enable && (read_burst_len != 9'd0) && (read_burst_count != 32'd0);
    assign beat_ok       = (state == DATA) && m_axi_rvalid && m_axis_tx_tready;
    assign burst_end     = beat_ok && m_axi_rlast;
    assign burst_cnt_inc = burst_cnt + 32'd1;
    assign burst_bytes   = ADDR_W'({read_burst_len, 4'b0000});

    // Length 256 wraps to 8'hFF in the low byte, which is exactly the AXI encoding.
    assign m_axi_arlen   = read_burst_len[7:0] - 8'd1;
    assign m_axi_arsize  = 3'h4;
    assign m_axi_arburst = 2'b01;

    assign read_busy        = (state != IDLE);
    assign m_axis_tx_tdata  = m_axi_rdata;
    assign m_axis_tx_tvalid = (state == DATA) && m_axi_rvalid;
    assign m_axi_rready     = (state == DATA) && m_axis_tx_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = IDLE;
        case (state)
            IDLE: state_nxt = start_ok ? ARM : IDLE;
            ARM:  state_nxt = tx_fifo_space_ready ? ADDR : ARM;
            ADDR: state_nxt = m_axi_arready ? DATA : ADDR;
            DATA: begin
                state_nxt = DATA;
                if (burst_end) begin
                    if ((burst_cnt_inc < read_burst_count) && !m_axi_rresp[1] && read_enable)
                        state_nxt = ARM;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi_araddr           <= '0;
            m_axi_arvalid          <= 1'b0;
            read_rresp             <= 2'b00;
            read_burst_tick        <= 1'b0;
            burst_cnt              <= 32'd0;
            read_total_burst_count <= 32'd0;
        end else begin
            read_burst_tick <= 1'b0;
            case (state)
                IDLE: begin
                    m_axi_araddr  <= read_base_address;
                    m_axi_arvalid <= 1'b0;
                    burst_cnt     <= 32'd0;
                    // The running total survives the IDLE pass between loops while enabled.
                    if (!start_ok)
                        read_total_burst_count <= 32'd0;
                end
                ARM: begin
                    m_axi_arvalid <= tx_fifo_space_ready;
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_araddr  <= m_axi_araddr + burst_bytes;
                    end
                end
                DATA: begin
                    if (burst_end) begin
                        read_rresp             <= m_axi_rresp;
                        read_burst_tick        <= 1'b1;
                        burst_cnt              <= burst_cnt_inc;
                        read_total_burst_count <= read_total_burst_count + 32'd1;
                    end
                end
                default: m_axi_arvalid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_dmac.sv
// Randomised bench for tx_dmac: an AXI read slave plus stream sink, checked
// against a burst-level reference of addresses, beat payloads, ticks and totals.
module tb_tx_dmac;
    localparam int AW   = 48;
    localparam int NONE = 100000;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          read_enable;
    logic          read_busy;
    logic [AW-1:0] read_base_address;
    logic [31:0]   read_burst_count;
    logic [8:0]    read_burst_len;
    logic [1:0]    read_rresp;
    logic          read_burst_tick;
    logic [31:0]   read_total_burst_count;
    logic          tx_fifo_space_ready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [127:0]  m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [127:0]  m_axis_tx_tdata;
    logic          m_axis_tx_tvalid;
    logic          m_axis_tx_tready;

    tx_dmac #(.ADDR_W(AW)) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .read_enable            (read_enable),
        .read_busy              (read_busy),
        .read_base_address      (read_base_address),
        .read_burst_count       (read_burst_count),
        .read_burst_len         (read_burst_len),
        .read_rresp             (read_rresp),
        .read_burst_tick        (read_burst_tick),
        .read_total_burst_count (read_total_burst_count),
        .tx_fifo_space_ready    (tx_fifo_space_ready),
        .m_axi_araddr           (m_axi_araddr),
        .m_axi_arlen            (m_axi_arlen),
        .m_axi_arsize           (m_axi_arsize),
        .m_axi_arburst          (m_axi_arburst),
        .m_axi_arvalid          (m_axi_arvalid),
        .m_axi_arready          (m_axi_arready),
        .m_axi_rdata            (m_axi_rdata),
        .m_axi_rresp            (m_axi_rresp),
        .m_axi_rlast            (m_axi_rlast),
        .m_axi_rvalid           (m_axi_rvalid),
        .m_axi_rready           (m_axi_rready),
        .m_axis_tx_tdata        (m_axis_tx_tdata),
        .m_axis_tx_tvalid       (m_axis_tx_tvalid),
        .m_axis_tx_tready       (m_axis_tx_tready)
    );

    always #5 aclk = ~aclk;

    int total_n = 0;
    int bad_n   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run configuration and reference state
    int            run_id = 0;
    logic [AW-1:0] run_base;
    int            run_len, run_count, nb, err_idx, stop_idx;
    int            burst_idx, ticks, tot_exp, beat, beats;
    logic          in_data;
    logic [AW-1:0] cur_addr;
    logic [1:0]    last_rresp;
    int            p_rv, p_tr, p_ar, p_sr;
    bit            ar_delay_mode, stall_mode, stall_done;
    int            ar_wait, stall_left;

    // Values sampled just before the active edge
    logic          hs_ar_q, hs_r_q, rlast_q, sr_q, arvalid_q;
    logic [1:0]    rresp_q;
    logic [7:0]    arlen_q;
    logic [AW-1:0] araddr_q;
    logic [127:0]  tdata_q;

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int i);
        logic [AW-1:0] step;
        step = AW'(run_len) << 4;
        return run_base + AW'(i % run_count) * step;
    endfunction

    function automatic logic [127:0] mk_data(input logic [AW-1:0] a, input int b);
        return {16'h0, a, 32'(b), 32'hBEEF_0000 ^ 32'(run_id)};
    endfunction

    task automatic clear_model();
        in_data = 1'b0; beat = 0; beats = 0; ar_wait = 0; stall_left = 0;
        hs_ar_q = 1'b0; hs_r_q = 1'b0; rlast_q = 1'b0; sr_q = 1'b0; arvalid_q = 1'b0;
        rresp_q = 2'b00; arlen_q = 8'h00; araddr_q = '0; tdata_q = '0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        m_axi_arready = 1'b0; m_axis_tx_tready = 1'b0; tx_fifo_space_ready = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_busy", read_busy, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_rresp", read_rresp, 0);
        check("rst_tick", read_burst_tick, 0);
        check("rst_total", read_total_burst_count, 0);
        check("rst_tvalid", m_axis_tx_tvalid, 0);
        check("rst_rready", m_axi_rready, 0);
    endtask

    // One clock: update the slave/reference with the last edge's handshakes,
    // check registered outputs, drive new inputs, then sample combinational ones.
    task automatic cycle();
        @(negedge aclk);
        if (hs_ar_q) begin
            check("one_ar", in_data, 0);
            check("araddr", araddr_q, exp_addr(burst_idx));
            check("arlen", arlen_q, run_len - 1);
            in_data  = 1'b1;
            beat     = 0;
            beats    = int'(arlen_q) + 1;
            cur_addr = araddr_q;
        end
        if (hs_r_q) begin
            check("beat", tdata_q, mk_data(exp_addr(burst_idx), beat));
            beat++;
            if (rlast_q) begin
                last_rresp = rresp_q;
                tot_exp++;
                burst_idx++;
                in_data = 1'b0;
            end
        end

        check("tick", read_burst_tick, hs_r_q && rlast_q);
        if (read_burst_tick) begin
            ticks++;
            check("total", read_total_burst_count, tot_exp);
            check("rresp", read_rresp, last_rresp);
        end
        if (arvalid_q && !hs_ar_q) begin
            check("ar_hold", m_axi_arvalid, 1);
            check("ar_stable", m_axi_araddr, araddr_q);
        end
        if (m_axi_arvalid && !arvalid_q)
            check("ar_latency", sr_q, 1);

        if (nb > 0 && ticks >= nb)
            read_enable = 1'b0;
        else if (in_data && burst_idx == stop_idx)
            read_enable = 1'b0;
        tx_fifo_space_ready = pct(p_sr);
        if (m_axi_arvalid) begin
            m_axi_arready = ar_delay_mode ? (ar_wait >= 5) : pct(p_ar);
            ar_wait++;
        end else begin
            m_axi_arready = pct(p_ar);
            ar_wait = 0;
        end
        if (in_data) begin
            if (!(m_axi_rvalid && !hs_r_q)) begin
                m_axi_rvalid = pct(p_rv);
                m_axi_rdata  = mk_data(cur_addr, beat);
                m_axi_rlast  = (beat == beats - 1);
                if (m_axi_rlast)
                    m_axi_rresp = (burst_idx == err_idx) ? 2'b10 : 2'($urandom_range(1));
                else
                    m_axi_rresp = 2'($urandom_range(3));
            end
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
        end
        if (stall_mode && !stall_done && in_data && burst_idx == 0 && beat == 4) begin
            stall_left = 5;
            stall_done = 1'b1;
        end
        if (stall_left > 0) begin
            m_axis_tx_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tx_tready = pct(p_tr);
        end

        #1;
        hs_ar_q   = m_axi_arvalid && m_axi_arready;
        hs_r_q    = m_axi_rvalid && m_axi_rready;
        rlast_q   = m_axi_rlast;
        rresp_q   = m_axi_rresp;
        sr_q      = tx_fifo_space_ready;
        arvalid_q = m_axi_arvalid;
        araddr_q  = m_axi_araddr;
        arlen_q   = m_axi_arlen;
        tdata_q   = m_axis_tx_tdata;
        if (in_data) begin
            check("tvalid", m_axis_tx_tvalid, m_axi_rvalid);
            check("rready", m_axi_rready, m_axis_tx_tready);
            check("tdata", m_axis_tx_tdata, m_axi_rdata);
            check("no_ar_in_data", m_axi_arvalid, 0);
        end else begin
            check("tvalid_off", m_axis_tx_tvalid, 0);
            check("rready_off", m_axi_rready, 0);
        end
    endtask

    task automatic setup_run(input logic [AW-1:0] base, input int len, input int count,
                             input int loops, input int err, input int stop,
                             input bit ard, input bit stl);
        run_id++;
        run_base = base; run_len = len; run_count = count;
        err_idx = err; stop_idx = stop;
        nb = count * loops;
        if (err + 1 < nb) nb = err + 1;
        if (stop + 1 < nb) nb = stop + 1;
        burst_idx = 0; ticks = 0; tot_exp = 0; in_data = 1'b0;
        ar_delay_mode = ard; stall_mode = stl; stall_done = 1'b0;
        read_base_address = base;
        read_burst_len    = 9'(len);
        read_burst_count  = 32'(count);
        read_enable       = 1'b1;
    endtask

    task automatic run(input logic [AW-1:0] base, input int len, input int count,
                       input int loops, input int err, input int stop,
                       input bit ard, input bit stl);
        int cyc;
        setup_run(base, len, count, loops, err, stop, ard, stl);
        cyc = 0;
        while (ticks < nb && cyc < 4000) begin
            cycle();
            cyc++;
        end
        check("run_done", ticks, nb);
        check("bursts", burst_idx, nb);
        repeat (3) cycle();
        check("busy_end", read_busy, 0);
        check("arvalid_end", m_axi_arvalid, 0);
        check("total_clr", read_total_burst_count, 0);
    endtask

    task automatic idle_hold(input int len, input int count);
        setup_run(48'h2000, len, count, 1, NONE, NONE, 1'b0, 1'b0);
        nb = 0;
        repeat (6) begin
            cycle();
            check("idle_busy", read_busy, 0);
            check("idle_arvalid", m_axi_arvalid, 0);
        end
        read_enable = 1'b0;
        cycle();
    endtask

    task automatic reset_mid();
        int cyc;
        setup_run(48'h0003_0000, 8, 3, 1, NONE, NONE, 1'b0, 1'b0);
        cyc = 0;
        while (!(in_data && burst_idx >= 1 && beat >= 2) && cyc < 2000) begin
            cycle();
            cyc++;
        end
        check("reached_data", in_data, 1);
        #2 aresetn = 1'b0;
        #1 check_reset_values();
        read_enable = 1'b0;
        clear_model();
        nb = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        cycle();
        check("post_rst_busy", read_busy, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        read_enable = 1'b0;
        read_base_address = '0;
        read_burst_count = 32'd0;
        read_burst_len = 9'd0;
        nb = 0; err_idx = NONE; stop_idx = NONE;
        run_base = '0; run_len = 1; run_count = 1;
        burst_idx = 0; ticks = 0; tot_exp = 0; last_rresp = 2'b00; cur_addr = '0;
        ar_delay_mode = 1'b0; stall_mode = 1'b0; stall_done = 1'b0;
        clear_model();
        p_rv = 100; p_tr = 100; p_ar = 100; p_sr = 100;
        repeat (3) @(negedge aclk);
        #1 check_reset_values();
        check("arsize", m_axi_arsize, 3'h4);
        check("arburst", m_axi_arburst, 2'b01);
        @(negedge aclk);
        aresetn = 1'b1;

        // Fully ready path, then a 5-cycle stream stall in mid-burst
        run(48'h1000, 16, 2, 1, NONE, NONE, 1'b0, 1'b0);
        run(48'h4000, 16, 1, 1, NONE, NONE, 1'b0, 1'b1);
        // Error response on the first burst stops the run
        p_rv = 80; p_tr = 80;
        run(48'h8000, 8, 4, 1, 0, NONE, 1'b0, 1'b0);
        check("err_rresp", read_rresp, 2'b10);
        reset_mid();
        // Single-beat bursts, delayed arready, idle on zero len/count
        run(48'h0100, 1, 3, 1, NONE, NONE, 1'b0, 1'b0);
        run(48'h0200, 4, 2, 1, NONE, NONE, 1'b1, 1'b0);
        idle_hold(0, 3);
        idle_hold(4, 0);
        // Address wrap, maximum length, enable held across loops, enable dropped mid-run
        p_ar = 60; p_sr = 60;
        run(48'hFFFF_FFFF_FF00, 16, 2, 1, NONE, NONE, 1'b0, 1'b0);
        run(48'h0001_0000, 256, 1, 1, NONE, NONE, 1'b0, 1'b0);
        run(48'h0002_0000, 4, 2, 3, NONE, NONE, 1'b0, 1'b0);
        run(48'h0005_0000, 6, 5, 1, NONE, 1, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            logic [AW-1:0] base;
            int len, count, err, stop;
            base  = {16'($urandom), 32'($urandom)};
            base[3:0] = 4'h0;
            len   = $urandom_range(48, 1);
            count = $urandom_range(4, 1);
            err   = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : NONE;
            stop  = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : NONE;
            p_rv  = $urandom_range(100, 40);
            p_tr  = $urandom_range(100, 40);
            p_ar  = $urandom_range(100, 40);
            p_sr  = $urandom_range(100, 40);
            run(base, len, count, 1, err, stop, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
